// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle control FSM sequencing PC, IR and single-cycle datapath units
module mc_ctrl #(
  parameter int CNT_W        = 32,
  parameter bit UNDEF_AS_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic [1:0]       npc_sel,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             ext_op,
  output logic             mem_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  state_t cur, nxt;
  logic   retire;

  logic is_r, i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal, defined;

  always_comb begin
    is_r    = (op == 6'b000000);
    i_addu  = is_r && (funct == 6'b100001);
    i_subu  = is_r && (funct == 6'b100011);
    i_jr    = is_r && (funct == 6'b001000);
    i_ori   = (op == 6'b001101);
    i_lui   = (op == 6'b001111);
    i_lw    = (op == 6'b100011);
    i_sw    = (op == 6'b101011);
    i_beq   = (op == 6'b000100);
    i_j     = (op == 6'b000010);
    i_jal   = (op == 6'b000011);
    defined = i_addu | i_subu | i_jr | i_ori | i_lui | i_lw | i_sw | i_beq | i_j | i_jal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    case (cur)
      FETCH: nxt = DECODE;
      DECODE: begin
        if (i_j || i_jal || i_jr) begin
          retire = 1'b1;
          nxt    = FETCH;
        end else if (!defined) begin
          retire = UNDEF_AS_NOP;
          nxt    = UNDEF_AS_NOP ? FETCH : TRAP;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        if (i_beq) begin
          retire = 1'b1;
          nxt    = FETCH;
        end else if (i_lw || i_sw) begin
          nxt = MEM;
        end else begin
          nxt = WB;
        end
      end
      MEM: begin
        if (i_sw) begin
          retire = 1'b1;
          nxt    = FETCH;
        end else begin
          nxt = WB;
        end
      end
      WB: begin
        retire = 1'b1;
        nxt    = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_we   = 1'b0;
    npc_sel = 2'b00;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    reg_dst = 2'b00;
    wd_sel  = 2'b00;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    ext_op  = 1'b0;
    mem_we  = 1'b0;
    if (!reset) begin
      // ALU/EXT selects stay valid through WB because the datapath units are not registered
      if (cur == EXEC || cur == MEM || cur == WB) begin
        if (i_subu || i_beq) alu_op = ALU_SUB;
        else if (i_ori)      alu_op = ALU_OR;
        else if (i_lui)      alu_op = ALU_LUI;
        else                 alu_op = ALU_ADD;
        alu_src = i_ori | i_lui | i_lw | i_sw;
        ext_op  = i_lw | i_sw | i_beq;
      end
      case (cur)
        FETCH: begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
        DECODE: begin
          if (i_j || i_jal) begin
            pc_we   = 1'b1;
            npc_sel = 2'b10;
          end
          if (i_jal) begin
            reg_we  = 1'b1;
            reg_dst = 2'b10;
            wd_sel  = 2'b10;
          end
          if (i_jr) begin
            pc_we   = 1'b1;
            npc_sel = 2'b11;
          end
        end
        EXEC: begin
          if (i_beq) begin
            pc_we   = zero;
            npc_sel = 2'b01;
          end
        end
        MEM: mem_we = i_sw;
        WB: begin
          reg_we  = 1'b1;
          reg_dst = (i_addu || i_subu) ? 2'b01 : 2'b00;
          wd_sel  = i_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against an instruction-level model
module tb_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_t, zero;
  logic [5:0] op, funct;

  logic m_pc_we, m_ir_we, m_reg_we, m_alu_src, m_ext_op, m_mem_we;
  logic [1:0] m_npc_sel, m_reg_dst, m_wd_sel;
  logic [2:0] m_alu_op, m_state;
  logic [31:0] m_retired;

  logic w_pc_we, w_ir_we, w_reg_we, w_alu_src, w_ext_op, w_mem_we;
  logic [1:0] w_npc_sel, w_reg_dst, w_wd_sel;
  logic [2:0] w_alu_op, w_state;
  logic [3:0] w_retired;

  logic t_pc_we, t_ir_we, t_reg_we, t_alu_src, t_ext_op, t_mem_we;
  logic [1:0] t_npc_sel, t_reg_dst, t_wd_sel;
  logic [2:0] t_alu_op, t_state;
  logic [31:0] t_retired;

  mc_ctrl #(.CNT_W(32), .UNDEF_AS_NOP(1'b1)) u_main (
    .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero),
    .pc_we(m_pc_we), .npc_sel(m_npc_sel), .ir_we(m_ir_we), .reg_we(m_reg_we),
    .reg_dst(m_reg_dst), .wd_sel(m_wd_sel), .alu_src(m_alu_src), .alu_op(m_alu_op),
    .ext_op(m_ext_op), .mem_we(m_mem_we), .state(m_state), .retired(m_retired));

  mc_ctrl #(.CNT_W(4), .UNDEF_AS_NOP(1'b1)) u_wrap (
    .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero),
    .pc_we(w_pc_we), .npc_sel(w_npc_sel), .ir_we(w_ir_we), .reg_we(w_reg_we),
    .reg_dst(w_reg_dst), .wd_sel(w_wd_sel), .alu_src(w_alu_src), .alu_op(w_alu_op),
    .ext_op(w_ext_op), .mem_we(w_mem_we), .state(w_state), .retired(w_retired));

  mc_ctrl #(.CNT_W(32), .UNDEF_AS_NOP(1'b0)) u_trap (
    .clk(clk), .reset(reset_t), .op(op), .funct(funct), .zero(zero),
    .pc_we(t_pc_we), .npc_sel(t_npc_sel), .ir_we(t_ir_we), .reg_we(t_reg_we),
    .reg_dst(t_reg_dst), .wd_sel(t_wd_sel), .alu_src(t_alu_src), .alu_op(t_alu_op),
    .ext_op(t_ext_op), .mem_we(t_mem_we), .state(t_state), .retired(t_retired));

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_UNDEF = 10;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_retired = 0;

  function automatic int n_cycles(input int k);
    if (k == K_J || k == K_JAL || k == K_JR || k == K_UNDEF) return 2;
    if (k == K_BEQ) return 3;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  task automatic set_instr(input int k);
    funct = 6'($urandom_range(63));
    case (k)
      K_ADDU:  begin op = 6'b000000; funct = 6'b100001; end
      K_SUBU:  begin op = 6'b000000; funct = 6'b100011; end
      K_JR:    begin op = 6'b000000; funct = 6'b001000; end
      K_ORI:   op = 6'b001101;
      K_LUI:   op = 6'b001111;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_BEQ:   op = 6'b000100;
      K_J:     op = 6'b000010;
      K_JAL:   op = 6'b000011;
      default: op = 6'b111111;
    endcase
  endtask

  // Expected controls for cycle `step` of an instruction, plus a mask of the fields the instruction defines
  task automatic exp_ctrl(input int k, input int step, input logic z,
                          output logic [17:0] v, output logic [17:0] msk);
    logic pw, iw, rw, as, eo, mw;
    logic [1:0] ns, rd, ws;
    logic [2:0] ao, st;
    logic sel_valid, ext_valid;
    pw = 0; iw = 0; rw = 0; as = 0; eo = 0; mw = 0; ns = 0; rd = 0; ws = 0; ao = 0;
    case (step)
      0: st = 3'd0;
      1: st = 3'd1;
      2: st = 3'd2;
      3: st = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
      default: st = 3'd4;
    endcase
    sel_valid = (st == 3'd2 || st == 3'd3);
    ext_valid = (k == K_ORI || k == K_LW || k == K_SW || k == K_BEQ);
    if (step == 0) begin pw = 1; iw = 1; ns = 2'b00; end
    if (step == 1 && (k == K_J || k == K_JAL)) begin pw = 1; ns = 2'b10; end
    if (step == 1 && k == K_JAL) begin rw = 1; rd = 2'b10; ws = 2'b10; end
    if (step == 1 && k == K_JR) begin pw = 1; ns = 2'b11; end
    case (k)
      K_SUBU:     begin ao = 3'b001; as = 0; end
      K_ORI:      begin ao = 3'b010; as = 1; eo = 0; end
      K_LUI:      begin ao = 3'b011; as = 1; end
      K_LW, K_SW: begin ao = 3'b000; as = 1; eo = 1; end
      K_BEQ:      begin ao = 3'b001; as = 0; eo = 1; end
      default:    begin ao = 3'b000; as = 0; end
    endcase
    if (k == K_BEQ && step == 2) begin pw = z; ns = 2'b01; end
    if (st == 3'd3 && k == K_SW) mw = 1;
    if (st == 3'd4) begin
      rw = 1;
      rd = (k == K_ADDU || k == K_SUBU) ? 2'b01 : 2'b00;
      ws = (k == K_LW) ? 2'b01 : 2'b00;
    end
    v = {pw, ns, iw, rw, rd, ws, as, ao, eo, mw, st};
    msk = {1'b1, {2{pw}}, 1'b1, 1'b1, {2{rw}}, {2{rw}}, sel_valid, {3{sel_valid}},
           sel_valid && ext_valid, 1'b1, 3'b111};
  endtask

  task automatic run_instr(input int k, input logic z);
    int cyc, n;
    logic [17:0] v, msk, act;
    n = n_cycles(k);
    set_instr(k);
    zero = z;
    cyc = 0;
    do begin
      #1;
      if (cyc < n) begin
        exp_ctrl(k, cyc, z, v, msk);
        act = {m_pc_we, m_npc_sel, m_ir_we, m_reg_we, m_reg_dst, m_wd_sel,
               m_alu_src, m_alu_op, m_ext_op, m_mem_we, m_state};
        total_cnt++;
        if ((act & msk) !== (v & msk))
          $display("FAIL ctrl kind%0d step%0d: got %h want %h", k, cyc, act & msk, v & msk);
        else pass_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
    end while (m_state !== 3'd0 && cyc < 8);
    total_cnt++;
    if (cyc !== n) $display("FAIL cycles kind%0d: got %0d want %0d", k, cyc, n);
    else pass_cnt++;
    exp_retired++;
    total_cnt++;
    if (m_retired !== 32'(exp_retired))
      $display("FAIL retired kind%0d: got %0d want %0d", k, m_retired, exp_retired);
    else pass_cnt++;
    total_cnt++;
    if (w_retired !== 4'(exp_retired))
      $display("FAIL retired4 kind%0d: got %0d want %0d", k, w_retired, exp_retired % 16);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_a = 1; reset_t = 1; op = 0; funct = 0; zero = 0;
    @(posedge clk); #1;
    total_cnt++;
    if ({m_pc_we, m_ir_we, m_reg_we, m_mem_we, m_npc_sel, m_reg_dst, m_wd_sel} !== 10'd0)
      $display("FAIL reset_outputs: got %b want 0",
               {m_pc_we, m_ir_we, m_reg_we, m_mem_we, m_npc_sel, m_reg_dst, m_wd_sel});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (m_state !== 3'd0 || m_retired !== 32'd0)
      $display("FAIL reset_state: got state %0d retired %0d want 0 0", m_state, m_retired);
    else pass_cnt++;
    reset_a = 0;
    exp_retired = 0;
    #1;
    total_cnt++;
    if (m_state !== 3'd0 || m_retired !== 32'd0 || m_ir_we !== 1'b1 || m_pc_we !== 1'b1 || m_npc_sel !== 2'b00)
      $display("FAIL fetch_after_reset: got st%0d ret%0d ir%b pc%b npc%b want st0 ret0 ir1 pc1 npc00",
               m_state, m_retired, m_ir_we, m_pc_we, m_npc_sel);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    run_instr(K_ADDU, 0); run_instr(K_ORI, 0); run_instr(K_LUI, 1); run_instr(K_LW, 0);
    run_instr(K_SW, 1); run_instr(K_BEQ, 1); run_instr(K_BEQ, 0); run_instr(K_J, 0);
    run_instr(K_JAL, 1); run_instr(K_JR, 0);
    total_cnt++;
    if (m_retired !== 32'd10) $display("FAIL seq_retired: got %0d want 10", m_retired);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_instr(int'($urandom_range(10)), 1'($urandom_range(1)));
  endtask

  task automatic test_mid_reset();
    set_instr(K_SW);
    zero = 0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (m_state !== 3'd3) $display("FAIL reach_mem: got %0d want 3", m_state);
    else pass_cnt++;
    reset_a = 1;
    #1;
    total_cnt++;
    if ({m_pc_we, m_ir_we, m_reg_we, m_mem_we} !== 4'd0)
      $display("FAIL mid_reset_enables: got %b want 0000", {m_pc_we, m_ir_we, m_reg_we, m_mem_we});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (m_state !== 3'd0 || m_retired !== 32'd0 || w_retired !== 4'd0)
      $display("FAIL mid_reset_state: got st%0d ret%0d ret4 %0d want 0 0 0", m_state, m_retired, w_retired);
    else pass_cnt++;
    reset_a = 0;
    exp_retired = 0;
  endtask

  task automatic test_wrap();
    repeat (15) run_instr(K_UNDEF, 0);
    total_cnt++;
    if (w_retired !== 4'd15) $display("FAIL wrap_pre: got %0d want 15", w_retired);
    else pass_cnt++;
    run_instr(K_UNDEF, 1);
    total_cnt++;
    if (w_retired !== 4'd0 || m_retired !== 32'd16)
      $display("FAIL wrap: got ret4 %0d ret %0d want 0 16", w_retired, m_retired);
    else pass_cnt++;
  endtask

  task automatic test_trap();
    reset_a = 1;
    set_instr(K_UNDEF);
    reset_t = 0;
    #1;
    total_cnt++;
    if (t_state !== 3'd0 || t_ir_we !== 1'b1) $display("FAIL trap_fetch: got st%0d ir%b want 0 1", t_state, t_ir_we);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (t_state !== 3'd1 || {t_pc_we, t_ir_we, t_reg_we, t_mem_we} !== 4'd0)
      $display("FAIL trap_decode: got st%0d en%b want 1 0000", t_state, {t_pc_we, t_ir_we, t_reg_we, t_mem_we});
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (t_state !== 3'd7 || {t_pc_we, t_ir_we, t_reg_we, t_mem_we} !== 4'd0 || t_retired !== 32'd0)
        $display("FAIL trap_hold%0d: got st%0d en%b ret%0d want 7 0000 0", i, t_state,
                 {t_pc_we, t_ir_we, t_reg_we, t_mem_we}, t_retired);
      else pass_cnt++;
    end
    reset_t = 1;
    #1;
    total_cnt++;
    if ({t_pc_we, t_ir_we, t_reg_we, t_mem_we} !== 4'd0)
      $display("FAIL trap_reset_en: got %b want 0000", {t_pc_we, t_ir_we, t_reg_we, t_mem_we});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (t_state !== 3'd0 || t_retired !== 32'd0)
      $display("FAIL trap_reset: got st%0d ret%0d want 0 0", t_state, t_retired);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_random();
    test_mid_reset();
    test_wrap();
    test_trap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
